// File: rtl/tag_array_pkg.sv
// Shared geometry and state encodings for the tag array controller.
// Imported by the sweep counter and the arbiter top.
package tag_array_pkg;

  localparam int NUM_ROWS    = 16;
  localparam int ADDR_WIDTH  = 4;
  localparam int NUM_BLOCKS  = 4;
  localparam int BLOCK_WIDTH = 8;
  localparam int ROW_WIDTH   = NUM_BLOCKS * BLOCK_WIDTH;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW =
    ADDR_WIDTH'(NUM_ROWS - 1);

endpackage

// File: rtl/tag_init_sweep.sv
// Row counter for the clear sweep.
// Restart wins over enable; done flags the last row.
module tag_init_sweep
  import tag_array_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_en,
  input  logic                  i_restart,
  output logic [ADDR_WIDTH-1:0] o_cnt,
  output logic                  o_done
);

  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_restart) begin
      cnt_d = '0;
    end else if (i_en) begin
      // Wraps to row 0 after the last row, ready for the next sweep.
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_done = (cnt_q == LAST_ROW);

endmodule

// File: rtl/tag_array_ctrl.sv
// Clear-sweep sequencer and read/write arbiter for the tag array.
// Same-row conflicts favour refills until a lookup has starved.
module tag_array_ctrl
  import tag_array_pkg::*;
#(
  parameter int TAG_WIDTH    = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_lk_valid,
  input  logic [ADDR_WIDTH-1:0] i_lk_addr,
  input  logic [TAG_WIDTH-1:0]  i_lk_tag,
  output logic                  o_lk_ready,
  input  logic                  i_fill_valid,
  input  logic [ADDR_WIDTH-1:0] i_fill_addr,
  input  logic [ROW_WIDTH-1:0]  i_fill_data,
  input  logic [NUM_BLOCKS-1:0] i_fill_wmask,
  output logic                  o_fill_ready,
  input  logic                  i_flush,
  output logic                  o_ta_r_valid,
  output logic [ADDR_WIDTH-1:0] o_ta_r_addr,
  output logic [TAG_WIDTH-1:0]  o_ta_tag,
  output logic                  o_ta_w_valid,
  output logic [ADDR_WIDTH-1:0] o_ta_w_addr,
  output logic [ROW_WIDTH-1:0]  o_ta_w_data,
  output logic [NUM_BLOCKS-1:0] o_ta_w_wmask,
  output logic                  o_init_busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e state_d, state_q;
  logic [SW-1:0] starve_d, starve_q;

  logic [ADDR_WIDTH-1:0] cnt;
  logic sweep_done;
  logic sweep_en;
  logic sweep_restart;

  logic run;
  logic conflict;
  logic lk_wins;

  assign run      = (state_q == S_RUN);
  assign conflict = i_lk_valid & i_fill_valid &
                    (i_lk_addr == i_fill_addr);
  assign lk_wins  = (starve_q == STARVE_MAX);

  assign sweep_restart = ~i_halt & i_flush;
  assign sweep_en      = ~i_halt & ~run & ~i_flush;

  tag_init_sweep u_sweep (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_en      (sweep_en),
    .i_restart (sweep_restart),
    .o_cnt     (cnt),
    .o_done    (sweep_done)
  );

  always_comb begin
    o_lk_ready   = 1'b0;
    o_fill_ready = 1'b0;
    o_ta_r_valid = 1'b0;
    o_ta_r_addr  = '0;
    o_ta_tag     = '0;
    o_ta_w_valid = 1'b0;
    o_ta_w_addr  = '0;
    o_ta_w_data  = '0;
    o_ta_w_wmask = '0;
    if (!i_halt) begin
      if (!run) begin
        o_ta_w_valid = 1'b1;
        o_ta_w_addr  = cnt;
        o_ta_w_wmask = '1;
      end else begin
        o_lk_ready   = ~(conflict & ~lk_wins);
        o_fill_ready = ~(conflict & lk_wins);
        o_ta_r_valid = i_lk_valid & o_lk_ready;
        o_ta_w_valid = i_fill_valid & o_fill_ready;
        if (o_ta_r_valid) begin
          o_ta_r_addr = i_lk_addr;
          o_ta_tag    = i_lk_tag;
        end
        if (o_ta_w_valid) begin
          o_ta_w_addr  = i_fill_addr;
          o_ta_w_data  = i_fill_data;
          o_ta_w_wmask = i_fill_wmask;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!i_halt) begin
      if (i_flush) begin
        state_d  = S_INIT;
        starve_d = '0;
      end else if (!run) begin
        if (sweep_done) state_d = S_RUN;
        starve_d = '0;
      end else if (i_lk_valid & conflict & ~o_lk_ready) begin
        starve_d = lk_wins ? starve_q : starve_q + SW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_INIT;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign o_init_busy = ~run;

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Directed bench for tag_array_ctrl: sweep, arbitration,
// starvation flip, halt, flush and async reset.
module tb_tag_array_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_halt;
  logic        i_lk_valid;
  logic [3:0]  i_lk_addr;
  logic [0:0]  i_lk_tag;
  logic        o_lk_ready;
  logic        i_fill_valid;
  logic [3:0]  i_fill_addr;
  logic [31:0] i_fill_data;
  logic [3:0]  i_fill_wmask;
  logic        o_fill_ready;
  logic        i_flush;
  logic        o_ta_r_valid;
  logic [3:0]  o_ta_r_addr;
  logic [0:0]  o_ta_tag;
  logic        o_ta_w_valid;
  logic [3:0]  o_ta_w_addr;
  logic [31:0] o_ta_w_data;
  logic [3:0]  o_ta_w_wmask;
  logic        o_init_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tag_array_ctrl #(.TAG_WIDTH(1), .STARVE_LIMIT(3)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_halt       (i_halt),
    .i_lk_valid   (i_lk_valid),
    .i_lk_addr    (i_lk_addr),
    .i_lk_tag     (i_lk_tag),
    .o_lk_ready   (o_lk_ready),
    .i_fill_valid (i_fill_valid),
    .i_fill_addr  (i_fill_addr),
    .i_fill_data  (i_fill_data),
    .i_fill_wmask (i_fill_wmask),
    .o_fill_ready (o_fill_ready),
    .i_flush      (i_flush),
    .o_ta_r_valid (o_ta_r_valid),
    .o_ta_r_addr  (o_ta_r_addr),
    .o_ta_tag     (o_ta_tag),
    .o_ta_w_valid (o_ta_w_valid),
    .o_ta_w_addr  (o_ta_w_addr),
    .o_ta_w_data  (o_ta_w_data),
    .o_ta_w_wmask (o_ta_w_wmask),
    .o_init_busy  (o_init_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_halt       = 1'b0;
    i_lk_valid   = 1'b0;
    i_lk_addr    = '0;
    i_lk_tag     = '0;
    i_fill_valid = 1'b0;
    i_fill_addr  = '0;
    i_fill_data  = '0;
    i_fill_wmask = '0;
    i_flush      = 1'b0;
  endtask

  task automatic sweep_rows(input int first, input int last,
                            input string tag);
    for (int r = first; r <= last; r++) begin
      #1;
      chk({tag, "_wv"}, 32'(o_ta_w_valid), 32'd1);
      chk({tag, "_wa"}, 32'(o_ta_w_addr), 32'(r));
      chk({tag, "_wd"}, o_ta_w_data, 32'd0);
      chk({tag, "_wm"}, 32'(o_ta_w_wmask), 32'hF);
      chk({tag, "_lkr"}, 32'(o_lk_ready), 32'd0);
      chk({tag, "_busy"}, 32'(o_init_busy), 32'd1);
      step();
    end
  endtask

  logic [4:0] st_wv;
  logic [4:0] st_rv;

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    #12;
    chk("rst_wv", 32'(o_ta_w_valid), 32'd1);
    chk("rst_wa", 32'(o_ta_w_addr), 32'd0);
    chk("rst_wm", 32'(o_ta_w_wmask), 32'hF);
    chk("rst_lkr", 32'(o_lk_ready), 32'd0);
    chk("rst_fr", 32'(o_fill_ready), 32'd0);
    chk("rst_rv", 32'(o_ta_r_valid), 32'd0);
    chk("rst_busy", 32'(o_init_busy), 32'd1);
    arst_n = 1'b1;
    step();
    // step() landed after one edge: row 0 was written on it
    chk("sw0_wa_post", 32'(o_ta_w_addr), 32'd1);
    sweep_rows(1, 15, "sw0");
    chk("sw0_busy_end", 32'(o_init_busy), 32'd0);
    chk("sw0_lkr_end", 32'(o_lk_ready), 32'd1);
    chk("sw0_fr_end", 32'(o_fill_ready), 32'd1);

    i_lk_valid   = 1'b1;
    i_lk_addr    = 4'd3;
    i_lk_tag     = 1'b1;
    i_fill_valid = 1'b1;
    i_fill_addr  = 4'd5;
    i_fill_data  = 32'hA5C3_1E77;
    i_fill_wmask = 4'h3;
    #1;
    chk("dual_rv", 32'(o_ta_r_valid), 32'd1);
    chk("dual_ra", 32'(o_ta_r_addr), 32'd3);
    chk("dual_tag", 32'(o_ta_tag), 32'd1);
    chk("dual_wv", 32'(o_ta_w_valid), 32'd1);
    chk("dual_wa", 32'(o_ta_w_addr), 32'd5);
    chk("dual_wd", o_ta_w_data, 32'hA5C3_1E77);
    chk("dual_wm", 32'(o_ta_w_wmask), 32'h3);
    step();

    i_lk_addr   = 4'd7;
    i_fill_addr = 4'd7;
    st_wv = 5'b10111;
    st_rv = 5'b01000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stv_wv", 32'(o_ta_w_valid), 32'(st_wv[c]));
      chk("stv_fr", 32'(o_fill_ready), 32'(st_wv[c]));
      chk("stv_rv", 32'(o_ta_r_valid), 32'(st_rv[c]));
      chk("stv_lkr", 32'(o_lk_ready), 32'(st_rv[c]));
      step();
    end

    idle_inputs();
    #1;
    chk("idle_rv", 32'(o_ta_r_valid), 32'd0);
    chk("idle_ra", 32'(o_ta_r_addr), 32'd0);
    chk("idle_wv", 32'(o_ta_w_valid), 32'd0);
    chk("idle_wd", o_ta_w_data, 32'd0);
    chk("idle_lkr", 32'(o_lk_ready), 32'd1);
    step();

    i_flush      = 1'b1;
    i_fill_valid = 1'b1;
    i_fill_addr  = 4'd2;
    i_fill_data  = 32'h1234_5678;
    i_fill_wmask = 4'hF;
    #1;
    chk("fl_wv", 32'(o_ta_w_valid), 32'd1);
    chk("fl_wa", 32'(o_ta_w_addr), 32'd2);
    chk("fl_wd", o_ta_w_data, 32'h1234_5678);
    step();
    idle_inputs();
    i_lk_valid = 1'b1;
    i_lk_addr  = 4'd4;
    sweep_rows(0, 5, "fl");

    i_halt = 1'b1;
    for (int h = 0; h < 4; h++) begin
      i_flush = (h == 1);
      #1;
      chk("h_wv", 32'(o_ta_w_valid), 32'd0);
      chk("h_rv", 32'(o_ta_r_valid), 32'd0);
      chk("h_lkr", 32'(o_lk_ready), 32'd0);
      chk("h_busy", 32'(o_init_busy), 32'd1);
      step();
    end
    i_halt  = 1'b0;
    i_flush = 1'b0;
    sweep_rows(6, 15, "hr");
    #1;
    chk("hr_busy_end", 32'(o_init_busy), 32'd0);
    chk("hr_lk_issue", 32'(o_ta_r_valid), 32'd1);
    step();

    idle_inputs();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    sweep_rows(0, 8, "pre_rst");
    chk("pre_rst_wa9", 32'(o_ta_w_addr), 32'd9);
    arst_n = 1'b0;
    #1;
    chk("ar_wa", 32'(o_ta_w_addr), 32'd0);
    chk("ar_wv", 32'(o_ta_w_valid), 32'd1);
    chk("ar_busy", 32'(o_init_busy), 32'd1);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    sweep_rows(1, 15, "ar");
    #1;
    chk("ar_busy_end", 32'(o_init_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_array_ctrl.md
# tag_array_ctrl

Sequencer and arbiter in front of the 16-row × 32-bit tag array. After reset, and on request, it clears every row with a hardware sweep. It then arbitrates each cycle between the lookup requester (read port) and the refill requester (write port). A same-row read/write hazard on the 1R1W SRAM is never issued, and a starvation guard keeps the lookup path from being locked out by refills. The block sits between the fetch/miss logic and the tag array and drives all of the array's request inputs.

## Interface
- TAG_WIDTH, 1, width of the lookup tag carried alongside a read
- STARVE_LIMIT, 3, consecutive conflict-stall cycles of a lookup before refill priority flips
- clk  in  1  clock
- arst_n  in  1  asynchronous, active-low reset
- i_halt  in  1  global stall; freezes the block and suppresses all issues
- i_lk_valid  in  1  lookup request
- i_lk_addr  in  4  lookup row
- i_lk_tag  in  TAG_WIDTH  tag passed to the array with the read
- o_lk_ready  out  1  lookup accepted this cycle when high with i_lk_valid
- i_fill_valid  in  1  refill write request
- i_fill_addr  in  4  refill row
- i_fill_data  in  32  refill row data (4 blocks × 8 bits)
- i_fill_wmask  in  4  per-block write enable
- o_fill_ready  out  1  refill accepted this cycle when high with i_fill_valid
- i_flush  in  1  one-cycle pulse; re-runs the clear sweep
- o_ta_r_valid, o_ta_r_addr[3:0], o_ta_tag[TAG_WIDTH-1:0]  out  to tag array read port
- o_ta_w_valid, o_ta_w_addr[3:0], o_ta_w_data[31:0], o_ta_w_wmask[3:0]  out  to tag array write port
- o_init_busy  out  1  sweep in progress

## Operation
- State machine has two states.
  - S_INIT: the sweep.
  - S_RUN: arbitration.
- Internal registers:
  - state
  - 4-bit row counter cnt
  - stall counter starve (width clog2(STARVE_LIMIT+1))
- S_INIT behaviour:
  - Drives o_ta_w_valid=1, o_ta_w_addr=cnt, o_ta_w_data=0, o_ta_w_wmask=4'hF.
  - Holds o_ta_r_valid=0, o_lk_ready=0, o_fill_ready=0.
  - cnt increments each non-halted cycle.
  - After cnt==15 is written: state→S_RUN, cnt→0.
- S_RUN, base rule: o_fill_ready=1 and o_lk_ready=1.
- S_RUN, conflict: i_lk_valid & i_fill_valid & (i_lk_addr==i_fill_addr).
  - Refill wins and o_lk_ready=0, unless starve==STARVE_LIMIT.
  - In that case the lookup wins and o_fill_ready=0.
- starve counter:
  - Increments on each cycle a valid lookup is refused because of a conflict.
  - Clears when a lookup issues or i_lk_valid is low.
  - Saturates at STARVE_LIMIT.
- Issue path:
  - o_ta_r_valid = i_lk_valid & o_lk_ready; read address and tag pass through.
  - o_ta_w_valid = i_fill_valid & o_fill_ready; write address, data and mask pass through.
  - When not issuing, address/data/tag outputs are 0.
- Different-row lookup and refill issue in the same cycle.
- i_flush:
  - In S_RUN, requests presented in the flush cycle still issue; S_INIT with cnt=0 is entered the next cycle.
  - In S_INIT, cnt restarts at 0.
  - starve clears.
- i_halt=1 (overrides everything):
  - All valid and ready outputs are 0; o_init_busy holds.
  - state, cnt and starve hold.
  - i_flush is ignored.
- o_init_busy = (state==S_INIT).

## Timing
- Reset values: state=S_INIT, cnt=0, starve=0, o_init_busy=1.
- While in reset, and with i_halt=0, outputs are o_ta_w_valid=1, o_ta_w_addr=0, o_ta_w_data=0, o_ta_w_wmask=4'hF, all readies 0, o_ta_r_valid=0.
- Sweep length:
  - Exactly 16 non-halted cycles.
  - The first non-halted cycle after reset release writes row 0.
  - o_lk_ready first rises on the 17th non-halted cycle.
- All request-side outputs are combinational from state and inputs: zero-cycle issue.
- The array returns lookup data one clock after issue; the controller adds no latency.
- Reset asserted mid-sweep or mid-run: immediate return to reset values; the sweep restarts from row 0.
- Halt in the middle of a sweep: the resumed sweep continues at the held cnt, with no row skipped or repeated.

## Structure
- Shared package/header tag_array_pkg holds:
  - NUM_ROWS=16, ADDR_WIDTH=4, NUM_BLOCKS=4, BLOCK_WIDTH=8, ROW_WIDTH=32
  - state encodings S_INIT=1'b0, S_RUN=1'b1
- Optional sub-module tag_init_sweep: row counter with restart, enable and done.
- Arbitration and starvation logic stay in tag_array_ctrl.

## Test plan
- Reset release with no halt → rows 0..15 written with data 0 and mask F on consecutive cycles, o_init_busy falls after row 15, o_lk_ready=1 on cycle 16.
- S_RUN: lookup row 3 with refill row 5 in the same cycle → both o_ta_r_valid and o_ta_w_valid high in that cycle.
- Lookup and refill both held on row 7 for 5 cycles with STARVE_LIMIT=3 → refill issues on cycles 0-2, lookup issues on cycle 3 (o_fill_ready=0), refill issues on cycle 4.
- Halt asserted for 4 cycles when cnt=6 → no writes during the halt; row 6 is written on the first cycle after the halt ends, then 7..15.
- i_flush in S_RUN with a refill to row 2 in the same cycle → the refill issues; the next cycle writes row 0 with data 0 and o_init_busy=1; lookups are refused for 16 cycles.
- arst_n pulsed low when cnt=9 → outputs return to reset values and the sweep restarts at row 0.
